// File: rtl/mips_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM and the datapath/ALU.
// Carries the IR fields and ALU zero flag toward the FSM, and every mux select,
// write enable, ALU opcode and debug state back toward the datapath.
// Ports: op/funct/zero (datapath -> fsm); iord..state_o (fsm -> datapath).
interface mips_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [3:0] alu_op;
  logic       illegal_op;
  logic [3:0] state_o;

  // Control FSM side.
  modport master (
    input  op, funct, zero,
    output iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_op, illegal_op, state_o
  );

  // Datapath side.
  modport slave (
    output op, funct, zero,
    input  iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_op, illegal_op, state_o
  );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main control FSM: fetch/decode/execute sequencing, datapath
// mux selects and write enables, and the 4-bit ALU opcode (consumes ALU zero for beq).
// Ports: clk, rst_n (async, active low), bus (mips_ctrl_if.master).
// Outputs are Moore decodes of the state; pc_en also follows zero combinationally.
module mips_ctrl_fsm #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0111
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t state;

  // R-type funct decode shared by EXEC (opcode select) and ALUWB (write suppress).
  logic       funct_ok;
  logic [3:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // State register. DECODE and MEMADR branch on op as presented in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          if (bus.op == OP_LW)      state <= MEMRD;
          else if (bus.op == OP_SW) state <= MEMWR;
          else                      state <= FETCH;
        end
        MEMRD:  state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  state <= FETCH;
        EXEC:   state <= ALUWB;
        ALUWB:  state <= FETCH;
        BRANCH: state <= FETCH;
        ADDIEX: state <= ADDIWB;
        ADDIWB: state <= FETCH;
        JUMP:   state <= FETCH;
        default: state <= FETCH;  // codes 12-15 recover in one edge
      endcase
    end
  end

  // Moore output decode. Reset is applied combinationally on top so that an
  // asserted rst_n kills every enable in the same cycle, including FETCH's.
  logic       iord_c, mem_write_c, ir_write_c, reg_write_c, reg_dst_c, mem_to_reg_c;
  logic       alu_src_a_c, pc_write_c, branch_c, illegal_c;
  logic [1:0] alu_src_b_c, pc_src_c;
  logic [3:0] alu_op_c;

  always_comb begin
    iord_c       = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_src_c     = 2'b00;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    illegal_c    = 1'b0;
    alu_op_c     = ALU_ADD;

    case (state)
      FETCH: begin
        alu_src_b_c = 2'b01;
        ir_write_c  = 1'b1;
        pc_write_c  = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_c = 1'b0;
          default:                                       illegal_c = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      MEMRD: iord_c = 1'b1;
      MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
      end
      MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
      end
      EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = funct_alu;
        illegal_c   = !funct_ok;
      end
      ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = funct_ok;  // an illegal funct must not corrupt the register file
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_SUB;
        pc_src_c    = 2'b01;
        branch_c    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      ADDIWB: reg_write_c = 1'b1;
      JUMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.iord       = rst_n & iord_c;
    bus.mem_write  = rst_n & mem_write_c;
    bus.ir_write   = rst_n & ir_write_c;
    bus.reg_write  = rst_n & reg_write_c;
    bus.reg_dst    = rst_n & reg_dst_c;
    bus.mem_to_reg = rst_n & mem_to_reg_c;
    bus.alu_src_a  = rst_n & alu_src_a_c;
    bus.alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
    bus.pc_src     = rst_n ? pc_src_c : 2'b00;
    bus.pc_en      = rst_n & (pc_write_c | (branch_c & bus.zero));
    bus.alu_op     = rst_n ? alu_op_c : ALU_ADD;
    bus.illegal_op = rst_n & illegal_c;
    bus.state_o    = state;
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: each cycle's expected output vector is
// queued when inputs are driven and popped when the DUT outputs are sampled.
module tb_mips_ctrl_fsm;
  typedef logic [20:0] vec_t;

  logic clk;
  logic rst_n;
  mips_ctrl_if bus ();

  mips_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Fields: state, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
  //         alu_src_a, alu_src_b, pc_src, pc_en, alu_op, illegal_op
  function automatic vec_t mk(input logic [3:0] st, input logic io, input logic mw,
                              input logic irw, input logic rw, input logic rd,
                              input logic m2r, input logic sa, input logic [1:0] sb,
                              input logic [1:0] ps, input logic pe,
                              input logic [3:0] aop, input logic ill);
    return {st, io, mw, irw, rw, rd, m2r, sa, sb, ps, pe, aop, ill};
  endfunction

  function automatic vec_t observe();
    return {bus.state_o, bus.iord, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
            bus.pc_en, bus.alu_op, bus.illegal_op};
  endfunction

  task automatic check(input string tag);
    vec_t exp;
    vec_t obs;
    obs = observe();
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Drive inputs for one cycle, queue the expectation, check mid-cycle.
  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input vec_t e);
    bus.op = o;
    bus.funct = f;
    bus.zero = z;
    sb_q.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  vec_t v_rst, v_fetch, v_decode;

  initial begin
    v_rst    = mk(4'd0, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0010, 0);
    v_fetch  = mk(4'd0, 0,0,1,0,0,0,0, 2'b01, 2'b00, 1, 4'b0010, 0);
    v_decode = mk(4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 0, 4'b0010, 0);

    rst_n = 1'b0;
    bus.op = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero = 1'b1;
    @(posedge clk);
    #1;

    // Reset held for three cycles: everything quiet, state parked in FETCH.
    for (int i = 0; i < 3; i++) step("reset_hold", 6'b100011, 6'b0, 1'b1, v_rst);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4 then back to 0.
    step("lw_fetch",  6'b100011, 6'b0, 1'b0, v_fetch);
    step("lw_decode", 6'b100011, 6'b0, 1'b0, v_decode);
    step("lw_memadr", 6'b100011, 6'b0, 1'b0, mk(4'd2, 0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 4'b0010, 0));
    step("lw_memrd",  6'b100011, 6'b0, 1'b0, mk(4'd3, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));
    step("lw_memwb",  6'b100011, 6'b0, 1'b0, mk(4'd4, 0,0,0,1,0,1,0, 2'b00, 2'b00, 0, 4'b0010, 0));

    // R-type sub then slt.
    step("sub_fetch",  6'b000000, 6'b100010, 1'b0, v_fetch);
    step("sub_decode", 6'b000000, 6'b100010, 1'b0, v_decode);
    step("sub_exec",   6'b000000, 6'b100010, 1'b0, mk(4'd6, 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 4'b0110, 0));
    step("sub_aluwb",  6'b000000, 6'b100010, 1'b0, mk(4'd7, 0,0,0,1,1,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));
    step("slt_fetch",  6'b000000, 6'b101010, 1'b0, v_fetch);
    step("slt_decode", 6'b000000, 6'b101010, 1'b0, v_decode);
    step("slt_exec",   6'b000000, 6'b101010, 1'b0, mk(4'd6, 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 4'b0111, 0));
    step("slt_aluwb",  6'b000000, 6'b101010, 1'b0, mk(4'd7, 0,0,0,1,1,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));

    // beq taken then not taken.
    step("beq1_fetch",  6'b000100, 6'b0, 1'b0, v_fetch);
    step("beq1_decode", 6'b000100, 6'b0, 1'b1, v_decode);
    step("beq1_branch", 6'b000100, 6'b0, 1'b1, mk(4'd8, 0,0,0,0,0,0,1, 2'b00, 2'b01, 1, 4'b0110, 0));
    step("beq0_fetch",  6'b000100, 6'b0, 1'b0, v_fetch);
    step("beq0_decode", 6'b000100, 6'b0, 1'b0, v_decode);
    step("beq0_branch", 6'b000100, 6'b0, 1'b0, mk(4'd8, 0,0,0,0,0,0,1, 2'b00, 2'b01, 0, 4'b0110, 0));

    // Illegal opcode: pulse in DECODE, straight back to FETCH.
    step("ill_fetch",  6'b111111, 6'b0, 1'b0, v_fetch);
    step("ill_decode", 6'b111111, 6'b0, 1'b0, mk(4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 0, 4'b0010, 1));

    // Illegal funct: pulse in EXEC, write suppressed in ALUWB.
    step("badfn_fetch",  6'b000000, 6'b000000, 1'b0, v_fetch);
    step("badfn_decode", 6'b000000, 6'b000000, 1'b0, v_decode);
    step("badfn_exec",   6'b000000, 6'b000000, 1'b0, mk(4'd6, 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 4'b0010, 1));
    step("badfn_aluwb",  6'b000000, 6'b000000, 1'b0, mk(4'd7, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));

    // addi and j.
    step("addi_fetch",  6'b001000, 6'b0, 1'b0, v_fetch);
    step("addi_decode", 6'b001000, 6'b0, 1'b0, v_decode);
    step("addi_ex",     6'b001000, 6'b0, 1'b0, mk(4'd9,  0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 4'b0010, 0));
    step("addi_wb",     6'b001000, 6'b0, 1'b0, mk(4'd10, 0,0,0,1,0,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));
    step("j_fetch",     6'b000010, 6'b0, 1'b0, v_fetch);
    step("j_decode",    6'b000010, 6'b0, 1'b0, v_decode);
    step("j_jump",      6'b000010, 6'b0, 1'b0, mk(4'd11, 0,0,0,0,0,0,0, 2'b00, 2'b10, 1, 4'b0010, 0));

    // sw with reset asserted in the middle of MEMWR.
    step("sw_fetch",  6'b101011, 6'b0, 1'b0, v_fetch);
    step("sw_decode", 6'b101011, 6'b0, 1'b0, v_decode);
    step("sw_memadr", 6'b101011, 6'b0, 1'b0, mk(4'd2, 0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 4'b0010, 0));
    sb_q.push_back(mk(4'd5, 1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0010, 0));
    @(negedge clk);
    check("sw_memwr");
    #1;
    rst_n = 1'b0;
    sb_q.push_back(v_rst);
    #1;
    check("sw_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_fetch",  6'b100011, 6'b0, 1'b0, v_fetch);
    step("post_rst_decode", 6'b100011, 6'b0, 1'b0, v_decode);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute bound on the run in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
endmodule
